// File: rtl/regfile_32.sv
// rtl/regfile_32.sv - 32-entry register file with two combinational read ports and busy-bit scoreboard
// Writes land at the clock edge; reads are mux slices over the stored bits plus optional WB forwarding.
module regfile_32 #(
  parameter int WIDTH    = 64,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       rd_addr_a,
  input  logic [4:0]       rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             wr_en,
  input  logic [4:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rsv_en,
  input  logic [4:0]       rsv_addr,
  output logic             busy_a,
  output logic             busy_b,
  output logic [31:0]      busy_vec
);

  localparam logic [4:0] ZIDX   = 5'(ZERO_REG);
  localparam bit         BYP_EN = (BYPASS != 0);

  logic [WIDTH-1:0] regs [32];
  logic [31:0]      busy_q;
  logic [31:0]      busy_d;
  logic [WIDTH-1:0] stored_a;
  logic [WIDTH-1:0] stored_b;
  logic             wr_live;
  logic             rsv_live;
  logic             fwd_a;
  logic             fwd_b;

  assign wr_live  = wr_en && (wr_addr != ZIDX);
  assign rsv_live = rsv_en && (rsv_addr != ZIDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      busy_q <= '0;
    end else begin
      if (wr_live) regs[wr_addr] <= wr_data;
      busy_q <= busy_d;
    end
  end

  // Set is applied after clear so a fresh reservation beats a retiring writer.
  always_comb begin
    busy_d = busy_q;
    if (wr_live)  busy_d[wr_addr]  = 1'b0;
    if (rsv_live) busy_d[rsv_addr] = 1'b1;
    busy_d[ZIDX] = 1'b0;
  end

  for (genvar k = 0; k < WIDTH; k++) begin : g_slice
    logic [31:0] col;
    for (genvar j = 0; j < 32; j++) begin : g_col
      assign col[j] = regs[j][k];
    end
    assign stored_a[k] = col[rd_addr_a];
    assign stored_b[k] = col[rd_addr_b];
  end

  assign fwd_a = BYP_EN && wr_live && (wr_addr == rd_addr_a);
  assign fwd_b = BYP_EN && wr_live && (wr_addr == rd_addr_b);

  assign rd_data_a = (rd_addr_a == ZIDX) ? '0 : (fwd_a ? wr_data : stored_a);
  assign rd_data_b = (rd_addr_b == ZIDX) ? '0 : (fwd_b ? wr_data : stored_b);

  assign busy_a   = (rd_addr_a != ZIDX) && busy_q[rd_addr_a] && !fwd_a;
  assign busy_b   = (rd_addr_b != ZIDX) && busy_q[rd_addr_b] && !fwd_b;
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_32.sv
// tb/tb_regfile_32.sv - bench for regfile_32, forwarding and non-forwarding instances side by side
module tb_regfile_32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  rd_addr_a, rd_addr_b, wr_addr, rsv_addr;
  logic        wr_en, rsv_en;
  logic [63:0] wr_data;

  logic [63:0] y_rda, y_rdb, n_rda, n_rdb;
  logic        y_ba, y_bb, n_ba, n_bb;
  logic [31:0] y_bv, n_bv;

  int passed = 0;
  int total  = 0;

  logic [63:0] mregs [32];
  logic [31:0] mbusy;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        rv;
    logic [4:0]  rva;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [63:0] ea;
    logic [63:0] eb;
    logic [31:0] ebv;
  } vec_t;

  vec_t tbl [7];

  always #5 clk = ~clk;

  regfile_32 #(.WIDTH(64), .ZERO_REG(31), .BYPASS(1)) u_byp (
    .clk(clk), .reset_n(reset_n), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(y_rda), .rd_data_b(y_rdb), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_a(y_ba), .busy_b(y_bb), .busy_vec(y_bv));

  regfile_32 #(.WIDTH(64), .ZERO_REG(31), .BYPASS(0)) u_nob (
    .clk(clk), .reset_n(reset_n), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(n_rda), .rd_data_b(n_rdb), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_a(n_ba), .busy_b(n_bb), .busy_vec(n_bv));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd31) return 64'h0;
    if (byp && wr_en && wr_addr == a) return wr_data;
    return mregs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    if (a == 5'd31) return 1'b0;
    if (byp && wr_en && wr_addr == a) return 1'b0;
    return mbusy[a];
  endfunction

  task automatic check_model(input string name);
    chk({name, "/byp_rda"}, y_rda, exp_rd(rd_addr_a, 1'b1));
    chk({name, "/byp_rdb"}, y_rdb, exp_rd(rd_addr_b, 1'b1));
    chk({name, "/byp_ba"},  64'(y_ba), 64'(exp_busy(rd_addr_a, 1'b1)));
    chk({name, "/byp_bb"},  64'(y_bb), 64'(exp_busy(rd_addr_b, 1'b1)));
    chk({name, "/byp_bv"},  64'(y_bv), 64'(mbusy));
    chk({name, "/nob_rda"}, n_rda, exp_rd(rd_addr_a, 1'b0));
    chk({name, "/nob_rdb"}, n_rdb, exp_rd(rd_addr_b, 1'b0));
    chk({name, "/nob_ba"},  64'(n_ba), 64'(exp_busy(rd_addr_a, 1'b0)));
    chk({name, "/nob_bb"},  64'(n_bb), 64'(exp_busy(rd_addr_b, 1'b0)));
    chk({name, "/nob_bv"},  64'(n_bv), 64'(mbusy));
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mregs[i] = 64'h0;
    mbusy = 32'h0;
  endtask

  // One clock edge; the model takes the pre-edge inputs and commits them after the edge.
  task automatic step();
    logic [63:0] nregs [32];
    logic [31:0] nbusy;
    for (int i = 0; i < 32; i++) nregs[i] = mregs[i];
    nbusy = mbusy;
    if (wr_en && wr_addr != 5'd31) begin
      nregs[wr_addr] = wr_data;
      nbusy[wr_addr] = 1'b0;
    end
    if (rsv_en && rsv_addr != 5'd31) nbusy[rsv_addr] = 1'b1;
    @(posedge clk);
    #1;
    if (reset_n) begin
      for (int i = 0; i < 32; i++) mregs[i] = nregs[i];
      mbusy = nbusy;
    end
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rsv_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 5'd3,  64'h1234_5678_9ABC_DEF0, 1'b0, 5'd0,  5'd3,  5'd3,  64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 32'h0};
    tbl[1] = '{1'b0, 5'd0,  64'h0,                   1'b0, 5'd0,  5'd4,  5'd3,  64'h0,                   64'h1234_5678_9ABC_DEF0, 32'h0};
    tbl[2] = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd31, 5'd31, 5'd31, 64'h0,                   64'h0,                   32'h0};
    tbl[3] = '{1'b1, 5'd7,  64'h11,                  1'b1, 5'd20, 5'd7,  5'd20, 64'h11,                  64'h0,                   32'h0010_0000};
    tbl[4] = '{1'b1, 5'd20, 64'h5555,                1'b0, 5'd0,  5'd20, 5'd7,  64'h5555,                64'h11,                  32'h0};
    tbl[5] = '{1'b1, 5'd0,  64'hABCD,                1'b1, 5'd0,  5'd0,  5'd31, 64'hABCD,                64'h0,                   32'h1};
    tbl[6] = '{1'b1, 5'd0,  64'h1,                   1'b0, 5'd0,  5'd0,  5'd4,  64'h1,                   64'h0,                   32'h0};

    reset_n = 1'b0;
    idle();
    wr_addr = 5'd0; wr_data = 64'h0; rsv_addr = 5'd0;
    rd_addr_a = 5'd5; rd_addr_b = 5'd31;
    model_clear();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_rda", y_rda, 64'h0);
    chk("reset_bv", 64'(y_bv), 64'h0);
    check_model("reset");

    for (int t = 0; t < 7; t++) begin
      wr_en = tbl[t].we; wr_addr = tbl[t].wa; wr_data = tbl[t].wd;
      rsv_en = tbl[t].rv; rsv_addr = tbl[t].rva;
      rd_addr_a = tbl[t].ra; rd_addr_b = tbl[t].rb;
      step();
      idle();
      #1;
      chk($sformatf("tbl%0d_rda", t), y_rda, tbl[t].ea);
      chk($sformatf("tbl%0d_rdb", t), y_rdb, tbl[t].eb);
      chk($sformatf("tbl%0d_bv", t), 64'(y_bv), 64'(tbl[t].ebv));
      check_model($sformatf("tbl%0d", t));
    end

    // Same-cycle forwarding with a reserved destination.
    rsv_en = 1'b1; rsv_addr = 5'd7;
    step();
    idle();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h22; rd_addr_a = 5'd7; rd_addr_b = 5'd20;
    #1;
    chk("byp_rda", y_rda, 64'h22);
    chk("byp_busy_a", 64'(y_ba), 64'h0);
    chk("nobyp_rda", n_rda, 64'h11);
    chk("nobyp_busy_a", 64'(n_ba), 64'h1);
    check_model("bypass");
    step();
    idle();
    #1;
    chk("after_byp_rda", n_rda, 64'h22);
    chk("after_byp_bv", 64'(y_bv), 64'h0);

    // Scoreboard set/clear ordering on reg 9.
    rd_addr_a = 5'd9; rd_addr_b = 5'd12;
    rsv_en = 1'b1; rsv_addr = 5'd9;
    step(); idle();
    chk("sb_set", 64'(y_bv), 64'h200);
    chk("sb_busy_a", 64'(y_ba), 64'h1);
    step(); step();
    chk("sb_hold", 64'(y_bv), 64'h200);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h99; rsv_en = 1'b1; rsv_addr = 5'd9;
    step(); idle();
    chk("sb_set_wins", 64'(y_bv), 64'h200);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h98;
    step(); idle();
    chk("sb_clear", 64'(y_bv), 64'h0);
    wr_en = 1'b1; wr_addr = 5'd13; wr_data = 64'h13; rsv_en = 1'b1; rsv_addr = 5'd12;
    step(); idle();
    chk("sb_diff_idx", 64'(y_bv), 64'h1000);
    rsv_en = 1'b1; rsv_addr = 5'd12;
    step(); idle();
    chk("sb_rereserve", 64'(y_bv), 64'h1000);
    check_model("sb");

    // Asynchronous reset in the middle of a cycle.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD_BEEF; rsv_en = 1'b1; rsv_addr = 5'd5;
    step(); idle();
    rd_addr_a = 5'd5;
    #1 chk("pre_rst_rda", y_rda, 64'hDEAD_BEEF);
    #2 reset_n = 1'b0;
    model_clear();
    #1;
    chk("async_rst_rda", y_rda, 64'h0);
    chk("async_rst_bv", 64'(y_bv), 64'h0);
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 64'h66; rsv_en = 1'b1; rsv_addr = 5'd6;
    step(); idle();
    rd_addr_b = 5'd6;
    #1;
    chk("rst_hold_rdb", y_rdb, 64'h0);
    chk("rst_hold_bv", 64'(y_bv), 64'h0);
    reset_n = 1'b1;
    #1;

    // Sweep all addresses.
    for (int i = 0; i <= 30; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 64'(i) * 64'h0101_0101_0101_0101;
      step();
    end
    idle();
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i); rd_addr_b = 5'(31 - i);
      #1;
      chk($sformatf("sweep_a%0d", i), y_rda, (i == 31) ? 64'h0 : 64'(i) * 64'h0101_0101_0101_0101);
      chk($sformatf("sweep_b%0d", 31 - i), n_rdb, (i == 0) ? 64'h0 : 64'(31 - i) * 64'h0101_0101_0101_0101);
    end

    for (int n = 0; n < 300; n++) begin
      wr_en = 1'($urandom_range(0, 1)); wr_addr = 5'($urandom_range(0, 31));
      wr_data = {$urandom, $urandom};
      rsv_en = 1'($urandom_range(0, 1)); rsv_addr = 5'($urandom_range(0, 31));
      rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rd_addr_b = 5'($urandom_range(0, 31));
      #1;
      check_model("rand");
      if (n == 150) begin
        reset_n = 1'b0;
        model_clear();
        #1 check_model("rand_rst");
        reset_n = 1'b1;
      end
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_32.md
Name: regfile_32

Overview:
- 32-entry architectural register file for the 5-stage pipeline.
- It sits upstream of the decode-stage operand latches. WB writes into it, and ID reads two operands from it.
- Each read port is built from WIDTH single-bit 32:1 mux slices. Slice k takes bit k of all 32 registers, and its select is the port's 5-bit read address.
- An in-flight-writer scoreboard (busy bits) drives hazard and stall detection.

Parameters:
- WIDTH, 64: data width of each register and of each data port.
- ZERO_REG, 31: index of the hardwired-zero register.
- BYPASS, 1: 1 enables same-cycle write-to-read forwarding; 0 returns the stored (old) value.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- rd_addr_a  input  5  read port A register index.
- rd_addr_b  input  5  read port B register index.
- rd_data_a  output  WIDTH  port A read data (combinational).
- rd_data_b  output  WIDTH  port B read data (combinational).
- wr_en  input  1  WB write strobe.
- wr_addr  input  5  WB destination index.
- wr_data  input  WIDTH  WB write data.
- rsv_en  input  1  ID reserves a destination for an issued instruction.
- rsv_addr  input  5  index being reserved.
- busy_a  output  1  register at rd_addr_a has a pending writer.
- busy_b  output  1  register at rd_addr_b has a pending writer.
- busy_vec  output  32  full scoreboard state.

Behaviour:
- Reset (reset_n=0):
  - Takes effect immediately, without waiting for clk.
  - All 32 registers clear to 0 and busy_vec clears to 0.
  - Resulting outputs: rd_data_a/b=0 and busy_a/b=0.
  - Holds while reset_n=0; writes and reservations are ignored.
  - A reset asserted mid-operation discards every pending reservation and stored value.
- Write:
  - On rising clk, if wr_en=1 and wr_addr!=ZERO_REG, then reg[wr_addr] <= wr_data.
  - The write is visible via storage from the next cycle.
  - A write to ZERO_REG is a no-op.
- Read:
  - Purely combinational, with zero-cycle latency.
  - rd_data_x = reg[rd_addr_x], except that rd_addr_x==ZERO_REG always yields 0.
  - Both ports are independent, and both may address the same register.
- Bypass, BYPASS=1: if wr_en=1, wr_addr==rd_addr_x, and rd_addr_x!=ZERO_REG, then rd_data_x=wr_data in the same cycle. This covers WB-to-ID in the same cycle.
- Bypass, BYPASS=0: the read returns the pre-edge stored value.
- Scoreboard, updated on rising clk:
  - rsv_en=1 and rsv_addr!=ZERO_REG sets busy_vec[rsv_addr].
  - wr_en=1 and wr_addr!=ZERO_REG clears busy_vec[wr_addr].
  - Set and clear of the same index in one cycle: set wins, because a new producer is in flight.
  - Set and clear of different indices in one cycle: both take effect.
  - Re-reserving an already-busy register leaves it busy. There is no count; the single-writer-in-flight rule is enforced by ID.
  - busy_vec[ZERO_REG] is constant 0.
- busy_x:
  - busy_x = busy_vec[rd_addr_x], combinational.
  - With BYPASS=1, busy_x is forced to 0 when wr_en=1 and wr_addr==rd_addr_x, because data is forwarded this cycle.
  - busy_x is 0 whenever rd_addr_x==ZERO_REG.
- Clearing a non-busy register via a write is legal and has no effect on the scoreboard.
- No X may propagate to the outputs after reset for any address value 0..31.

Test Plan:
- Reset:
  - Stimulus: assert reset_n=0 between clk edges after writing reg[5]=64'hDEAD_BEEF.
  - Required response: rd_data_a (addr 5)=0 immediately; busy_vec=0.
- Write then read:
  - Stimulus: wr_en=1, wr_addr=3, wr_data=64'h1234_5678_9ABC_DEF0 at one edge; next cycle rd_addr_a=3, rd_addr_b=3.
  - Required response: both ports = 64'h1234_5678_9ABC_DEF0.
  - Also check: reg[4] still reads 0.
- Zero register:
  - Stimulus: write 64'hFFFF_FFFF_FFFF_FFFF to addr 31, and rsv_en with rsv_addr=31.
  - Required response: rd_data_a (addr 31)=0, busy_a=0, busy_vec[31]=0.
- Bypass:
  - Stimulus: BYPASS=1, reg[7]=64'h11, same cycle wr_en=1, wr_addr=7, wr_data=64'h22, rd_addr_a=7.
  - Required response: rd_data_a=64'h22 and busy_a=0 before the edge.
  - Repeat with BYPASS=0: rd_data_a=64'h11.
- Scoreboard:
  - Stimulus: rsv on addr 9 at edge N.
  - Required response: busy_vec[9]=1 after N.
  - Stimulus: at edge N+3 wr_en addr 9 with rsv_en addr 9 simultaneously.
  - Required response: busy_vec[9] stays 1.
  - Stimulus: a write alone to addr 9 at N+4.
  - Required response: busy_vec[9]=0.
- Sweep:
  - Stimulus: write reg[i]=i*64'h0101_0101_0101_0101 for i=0..30, then read all i on port A and 31-i on port B.
  - Required response: every read value matches; addr 31 reads 0.
